// File: rtl/johnson_counter_param_if.sv
// johnson_counter_param_if: control and status bundle of the Johnson/ring phase counter.
interface johnson_counter_param_if #(
   parameter int WIDTH   = 4,
   parameter int PHASE_W = $clog2(2*WIDTH)
);
   logic en, dir, clear, load;
   logic [WIDTH-1:0] load_val, q;
   logic [PHASE_W-1:0] phase;
   logic legal, tick, err;
   modport master (output en, dir, clear, load, load_val, input q, phase, legal, tick, err);
   modport slave (input en, dir, clear, load, load_val, output q, phase, legal, tick, err);
endinterface

// File: rtl/johnson_counter_param.sv
// johnson_counter_param: parametrised Johnson/ring phase counter with illegal-state
// self-correction, binary phase decode, wrap tick and correction-error pulse.
module johnson_counter_param #(
   parameter int WIDTH   = 4,
   parameter int MODE    = 0,
   parameter int PHASE_W = $clog2(2*WIDTH)
) (
   input logic clk,
   input logic reset,
   johnson_counter_param_if.slave bus
);
   localparam logic [WIDTH-1:0] HOME = (MODE == 0) ? '0 : WIDTH'(1);
   logic [WIDTH-1:0] q, inv, nxt;
   logic legal, tick_r, err_r, stepping;
   int pc, idx;
   always_comb begin
      pc = 0;
      idx = 0;
      for (int i = 0; i < WIDTH; i++) begin
         pc = pc + int'(q[i]);
         if (q[i]) idx = i;
      end
   end
   assign inv = ~q;
   // Thermometer codes: ones packed at bit0 (q & (q+1) == 0) or packed at the top bit.
   assign legal = (MODE == 0)
      ? (((q & (q + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0))
      : (pc == 1);
   assign nxt = (MODE == 0)
      ? (bus.dir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]})
      : (bus.dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]});
   assign stepping = !bus.clear && !bus.load && bus.en;
   assign bus.q = q;
   assign bus.legal = legal;
   assign bus.tick = tick_r;
   assign bus.err = err_r;
   assign bus.phase = !legal ? '0
      : (MODE != 0) ? PHASE_W'(idx)
      : (q[0] || q == '0) ? PHASE_W'(pc)
      : PHASE_W'(2*WIDTH - pc);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         q <= HOME;
         tick_r <= 1'b0;
         err_r <= 1'b0;
      end else begin
         q <= bus.clear ? HOME : bus.load ? bus.load_val : !bus.en ? q : legal ? nxt : HOME;
         tick_r <= stepping && legal && nxt == HOME;
         err_r <= stepping && !legal;
      end
endmodule

// File: tb/tb_johnson_counter_param.sv
// tb_johnson_counter_param: directed and random checks of Johnson (W=4) and ring (W=5)
// counters against a phase-table reference model.
module tb_johnson_counter_param;
   logic clk = 1'b0, reset = 1'b1;
   int n_chk = 0, n_fail = 0;
   logic [31:0] jq, rq;
   logic jt, je, rt, re;
   johnson_counter_param_if #(.WIDTH(4)) ij ();
   johnson_counter_param_if #(.WIDTH(5)) ir ();
   johnson_counter_param #(.WIDTH(4), .MODE(0)) dut_j (.clk(clk), .reset(reset), .bus(ij));
   johnson_counter_param #(.WIDTH(5), .MODE(1)) dut_r (.clk(clk), .reset(reset), .bus(ir));
   always #5 clk = ~clk;
   // Reference: the legal sequence is a table indexed by phase; anything off the table is illegal.
   function automatic logic [31:0] qof(int w, int m, int p);
      if (m != 0) return 32'(1) << p;
      if (p <= w) return (32'(1) << p) - 1;
      return ((32'(1) << w) - 1) ^ ((32'(1) << (p - w)) - 1);
   endfunction
   function automatic int phof(int w, int m, logic [31:0] v);
      for (int p = 0; p < (m != 0 ? w : 2*w); p++) if (qof(w, m, p) == v) return p;
      return -1;
   endfunction
   task automatic model(input int w, m, input logic e, d, c, l, input logic [31:0] lv,
                        inout logic [31:0] mq, output logic mt, me);
      int n, p;
      n = (m != 0) ? w : 2*w;
      p = phof(w, m, mq);
      mt = 1'b0;
      me = 1'b0;
      if (c) mq = qof(w, m, 0);
      else if (l) mq = lv;
      else if (e && p < 0) begin mq = qof(w, m, 0); me = 1'b1; end
      else if (e) begin
         p = d ? (p + 1) % n : (p + n - 1) % n;
         mq = qof(w, m, p);
         mt = (p == 0);
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string s);
      int pj, pr;
      pj = phof(4, 0, jq);
      pr = phof(5, 1, rq);
      chk({s, "_j_q"}, 32'(ij.q), jq);
      chk({s, "_j_phase"}, 32'(ij.phase), 32'(pj < 0 ? 0 : pj));
      chk({s, "_j_legal"}, 32'(ij.legal), 32'(pj >= 0));
      chk({s, "_j_tick"}, 32'(ij.tick), 32'(jt));
      chk({s, "_j_err"}, 32'(ij.err), 32'(je));
      chk({s, "_r_q"}, 32'(ir.q), rq);
      chk({s, "_r_phase"}, 32'(ir.phase), 32'(pr < 0 ? 0 : pr));
      chk({s, "_r_legal"}, 32'(ir.legal), 32'(pr >= 0));
      chk({s, "_r_tick"}, 32'(ir.tick), 32'(rt));
      chk({s, "_r_err"}, 32'(ir.err), 32'(re));
   endtask
   task automatic model_reset();
      jq = 32'h0; jt = 1'b0; je = 1'b0;
      rq = 32'h1; rt = 1'b0; re = 1'b0;
   endtask
   task automatic drive_j(input logic e, d, c, l, input logic [3:0] lv);
      ij.en = e; ij.dir = d; ij.clear = c; ij.load = l; ij.load_val = lv;
   endtask
   task automatic drive_r(input logic e, d, c, l, input logic [4:0] lv);
      ir.en = e; ir.dir = d; ir.clear = c; ir.load = l; ir.load_val = lv;
   endtask
   task automatic cyc(input string s);
      @(posedge clk);
      model(4, 0, ij.en, ij.dir, ij.clear, ij.load, 32'(ij.load_val), jq, jt, je);
      model(5, 1, ir.en, ir.dir, ir.clear, ir.load, 32'(ir.load_val), rq, rt, re);
      #1 check_all(s);
   endtask
   task automatic async_reset(input string s);
      #3 reset = 1'b1;
      model_reset();
      #1 check_all(s);
      @(posedge clk);
      #2 reset = 1'b0;
   endtask
   initial begin
      drive_j(0, 0, 0, 0, 4'h0);
      drive_r(0, 0, 0, 0, 5'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all("reset");
      #3 reset = 1'b0;
      drive_j(1, 1, 0, 0, 4'h0);
      repeat (9) cyc("j_up");
      drive_j(0, 0, 1, 0, 4'h0);
      cyc("j_clear");
      drive_j(1, 0, 0, 0, 4'h0);
      repeat (2) cyc("j_down");
      drive_j(1, 1, 0, 0, 4'h0);
      cyc("j_dir_up");
      drive_j(1, 0, 0, 0, 4'h0);
      cyc("j_dir_down");
      drive_j(0, 0, 0, 1, 4'b0101);
      cyc("j_load_bad");
      drive_j(0, 1, 0, 0, 4'h0);
      repeat (2) cyc("j_hold_bad");
      drive_j(1, 1, 0, 0, 4'h0);
      repeat (2) cyc("j_correct");
      drive_j(0, 0, 0, 1, 4'b0111);
      cyc("j_load7");
      drive_j(1, 1, 1, 1, 4'b0101);
      cyc("j_clr_wins");
      drive_j(0, 0, 0, 1, 4'b0101);
      cyc("j_load_bad2");
      drive_j(1, 1, 0, 1, 4'b0110);
      cyc("j_load_wins");
      drive_j(0, 0, 0, 0, 4'h0);
      drive_r(1, 1, 0, 0, 5'h0);
      repeat (5) cyc("r_up");
      drive_r(1, 0, 0, 0, 5'h0);
      repeat (2) cyc("r_down");
      drive_r(0, 0, 0, 1, 5'h0);
      cyc("r_load0");
      drive_r(1, 1, 0, 0, 5'h0);
      repeat (2) cyc("r_correct");
      drive_r(0, 0, 0, 0, 5'h0);
      drive_j(0, 0, 1, 0, 4'h0);
      cyc("j_clear2");
      drive_j(1, 1, 0, 0, 4'h0);
      drive_r(1, 1, 0, 0, 5'h0);
      repeat (5) cyc("j_to_1110");
      drive_j(0, 0, 0, 0, 4'h0);
      drive_r(0, 0, 0, 0, 5'h0);
      async_reset("async_rst");
      drive_j(1, 1, 0, 0, 4'h0);
      repeat (2) cyc("j_after_rst");
      drive_j(0, 0, 0, 1, 4'b1001);
      drive_r(0, 0, 0, 1, 5'b00110);
      cyc("load_bad3");
      drive_j(1, 1, 0, 0, 4'h0);
      drive_r(1, 1, 0, 0, 5'h0);
      cyc("err_pulse");
      async_reset("async_rst_err");
      for (int k = 0; k < 400; k++) begin
         drive_j($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0, 4'($urandom));
         drive_r($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0, 5'($urandom));
         cyc("rnd");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
- Parametrised successor to the fixed 4-bit Johnson counter. Configurable width, twisted-ring (Johnson) or plain ring coding, enable, up/down direction, synchronous clear and parallel load.
- Adds illegal-state self-correction, a binary phase index, a wrap tick and a correction-error pulse.
- Used as a phase/sequence generator for timing strobes and multiphase enables in sequential-logic designs.

Parameters:
- WIDTH, 4, number of state flops; legal range 2..32.
- MODE, 0, 0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states, one-hot).
- PHASE_W, $clog2(2*WIDTH), width of the phase output (derived; do not override).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  step enable; state holds when low.
- dir  input  1  1 = step up, 0 = step down.
- clear  input  1  synchronous return to the home state.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value taken on load.
- q  output  WIDTH  registered counter state.
- phase  output  PHASE_W  binary phase index of q (combinational decode of q).
- legal  output  1  high when q is a legal state for MODE (combinational).
- tick  output  1  registered one-cycle pulse: q entered phase 0 by a normal step.
- err  output  1  registered one-cycle pulse: a correction was applied on the previous edge.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
  - Home state: q = 0 when MODE = 0; q = 1 (bit0 set) when MODE = 1.
  - On reset: q = home, tick = 0, err = 0.
- Priority at each rising edge: clear, then load, then correction, then step, then hold.
  - clear: q <= home; tick <= 0; err <= 0.
  - load: q <= load_val unchanged, even if illegal; tick <= 0; err <= 0.
  - correction: when en = 1 and legal = 0, q <= home, err <= 1, tick <= 0. No step occurs that cycle.
  - step: when en = 1 and legal = 1, q <= next state per the rules below. tick <= 1 iff the new phase is 0. err <= 0.
  - hold: when en = 0 and no clear or load, q holds; tick <= 0; err <= 0. An illegal q is not corrected while en = 0.
- Johnson step (MODE 0):
  - up: q[0] <= ~q[WIDTH-1], q[i] <= q[i-1].
  - down: q[WIDTH-1] <= ~q[0], q[i] <= q[i+1].
  - Up and down are exact inverses.
- Johnson legality and phase:
  - Legal states are the 2*WIDTH thermometer patterns: contiguous ones anchored at bit0, or contiguous ones anchored at bit WIDTH-1, including all-0 and all-1.
  - phase = popcount(q) when q[0] = 1 or q = 0; otherwise phase = 2*WIDTH - popcount(q).
- Ring step (MODE 1):
  - up: rotate left (bit WIDTH-1 moves to bit0).
  - down: rotate right.
- Ring legality and phase: legal iff exactly one bit is set; phase = index of the set bit (0..WIDTH-1).
- phase is 0 whenever legal = 0.
- Wrap:
  - Up from the last phase (2*WIDTH-1 in Johnson, WIDTH-1 in ring) goes to phase 0 and pulses tick.
  - Down from phase 0 goes to the last phase with no tick.
- Direction change: takes effect on the same edge; no extra latency.
- Latency: q, tick and err update 1 cycle after the controlling inputs. phase and legal follow q combinationally.
- Reset mid-operation: q goes to home immediately (asynchronous); tick and err clear. The first step after reset release is normal.

Test Plan:
- WIDTH=4, MODE=0, en=1, dir=1 for 9 cycles after reset -> q = 0001,0011,0111,1111,1110,1100,1000,0000,0001; phase 1..7,0,1; tick high only on the 0000 cycle.
- WIDTH=4, MODE=0, dir=0 from reset -> q = 1000 (phase 7), then 1100 (phase 6); no tick. Toggling dir mid-run reverses on the next edge with no skipped state.
- WIDTH=4, MODE=0, load=1 with load_val=0101 -> q = 0101, legal = 0, phase = 0, err = 0. Next edge with en=1 -> q = 0000, err = 1 for one cycle, tick = 0. Same load with en=0 -> q holds 0101.
- WIDTH=5, MODE=1, en=1, dir=1 -> q = 00010,00100,01000,10000,00001 with phase 1,2,3,4,0; tick on 00001. load_val=00000 then en -> q = 00001, err = 1.
- Simultaneous clear=1, load=1, en=1 at q=0111 -> q = 0000, tick = 0, err = 0. Simultaneous load and en on an illegal q -> load wins, err = 0.
- Assert reset asynchronously between clock edges at q=1110 -> q = 0000, tick = 0, err = 0 before the next edge; after release, counting resumes 0001,0011.
